// File: rtl/mem_test_pkg.sv
// Shared types and constants for the memory test generator.
package mem_test_pkg;

    localparam int unsigned DEF_DATA_WIDTH       = 64;
    localparam int unsigned DEF_ADDR_WIDTH       = 26;
    localparam int unsigned DEF_BYTEEN_WIDTH     = 8;
    localparam int unsigned DEF_BURSTCOUNT_WIDTH = 7;
    localparam int unsigned DEF_RD_LAT           = 4;
    localparam int unsigned DEF_MAX_OUTSTANDING  = 8;

    // Right-shifting Galois mask for taps 64,63,61,60
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ISSUE,
        ST_RD_ISSUE,
        ST_RD_DRAIN,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/mem_test_pattern.sv
// Test pattern word generator: incrementing sequence, or a Galois LFSR
// when MEM_TEST_LFSR_EN is defined.
module mem_test_pattern
    import mem_test_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  advance,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic [DATA_WIDTH-1:0] word
);

    logic [DATA_WIDTH-1:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        if (load) begin
`ifdef MEM_TEST_LFSR_EN
            word_d = (seed == '0) ? DATA_WIDTH'(1) : seed;
`else
            word_d = seed;
`endif
        end else if (advance) begin
`ifdef MEM_TEST_LFSR_EN
            word_d = (word_q >> 1) ^ (word_q[0] ? DATA_WIDTH'(LFSR_TAPS) : '0);
`else
            word_d = word_q + DATA_WIDTH'(1);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) word_q <= '0;
        else        word_q <= word_d;
    end

    assign word = word_q;

endmodule

// File: rtl/mem_test_gen.sv
// Memory write/read-back test generator. Pattern selected by MEM_TEST_LFSR_EN
// (LFSR when defined, incrementing words otherwise).
module mem_test_gen
    import mem_test_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int unsigned BYTEEN_WIDTH     = DEF_BYTEEN_WIDTH,
    parameter int unsigned BURSTCOUNT_WIDTH = DEF_BURSTCOUNT_WIDTH,
    parameter int unsigned RD_LAT           = DEF_RD_LAT,
    parameter int unsigned MAX_OUTSTANDING  = DEF_MAX_OUTSTANDING
) (
    input  logic                        pClk,
    input  logic                        SoftReset_n,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    input  logic [ADDR_WIDTH-1:0]       num_words,
    input  logic [DATA_WIDTH-1:0]       seed,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        timeout_err,
    output logic [31:0]                 err_count,
    output logic [ADDR_WIDTH-1:0]       first_err_addr,
    output logic                        write,
    output logic                        read,
    output logic [DATA_WIDTH-1:0]       writedata,
    output logic [ADDR_WIDTH-1:0]       address,
    output logic [BYTEEN_WIDTH-1:0]     byteenable,
    output logic [BURSTCOUNT_WIDTH-1:0] burstcount,
    output logic [2:0]                  readdata_sel,
    output logic                        read_ddr_data,
    input  logic                        ddr_data_ready,
    input  logic [DATA_WIDTH-1:0]       readdata,
    input  logic                        cmd_fifo_full,
    input  logic                        ddr_write_timeout,
    input  logic                        ddr_read_timeout
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    state_e                  state_q, state_d;
    logic                    busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic                    tmo_q, tmo_d, cmd_valid_q, cmd_valid_d, pop_q, pop_d;
    logic [31:0]             err_q, err_d;
    logic [ADDR_WIDTH-1:0]   ferr_q, ferr_d, base_q, base_d, num_q, num_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d, cmp_addr_q, cmp_addr_d, address_q, address_d;
    logic [DATA_WIDTH-1:0]   writedata_q, writedata_d;
    logic [OUT_W-1:0]        outst_q, outst_d;
    logic [RD_LAT-1:0]       vld_q, vld_d;

    logic                    cmd_accept, wr_fire, rd_fire, sample, rd_phase;
    logic                    pat_load, wr_adv, exp_adv;
    logic [DATA_WIDTH-1:0]   wr_word, exp_word;

    mem_test_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_wr_pat (
        .clk(pClk), .rst_n(SoftReset_n), .load(pat_load), .advance(wr_adv),
        .seed(seed), .word(wr_word)
    );

    mem_test_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_exp_pat (
        .clk(pClk), .rst_n(SoftReset_n), .load(pat_load), .advance(exp_adv),
        .seed(seed), .word(exp_word)
    );

    // A loaded command is held until the queue accepts it; the pulse never
    // appears in a cycle where the queue reports full.
    assign cmd_accept = cmd_valid_q && !cmd_fifo_full;
    assign wr_fire    = cmd_accept && (state_q == ST_WR_ISSUE);
    assign rd_fire    = cmd_accept && (state_q == ST_RD_ISSUE);
    assign rd_phase   = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_DRAIN);
    assign sample     = vld_q[RD_LAT-1] && rd_phase;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        ferr_d      = ferr_q;
        base_d      = base_q;
        num_d       = num_q;
        cnt_d       = cnt_q;
        cmp_addr_d  = cmp_addr_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        cmd_valid_d = cmd_valid_q;
        pat_load    = 1'b0;
        wr_adv      = 1'b0;
        exp_adv     = 1'b0;
        outst_d     = outst_q + OUT_W'(rd_fire) - OUT_W'(pop_q);
        vld_d       = (vld_q << 1) | RD_LAT'(pop_q);
        pop_d       = rd_phase && ddr_data_ready && (outst_q != '0) && !pop_q;

        // Compare returned data against the regenerated stream in issue order
        if (sample) begin
            exp_adv    = 1'b1;
            cmp_addr_d = cmp_addr_q + ADDR_WIDTH'(1);
            if (readdata != exp_word) begin
                if (err_q != '1)  err_d  = err_q + 32'd1;
                if (err_q == '0)  ferr_d = cmp_addr_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d     = 1'b1;
                    err_d      = '0;
                    ferr_d     = '0;
                    tmo_d      = 1'b0;
                    pass_d     = 1'b0;
                    base_d     = base_addr;
                    num_d      = num_words;
                    cnt_d      = '0;
                    cmp_addr_d = base_addr;
                    pat_load   = 1'b1;
                    if (num_words == '0) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = ST_WR_ISSUE;
                    end
                end
            end
            ST_WR_ISSUE: begin
                if (cmd_accept) begin
                    cmd_valid_d = 1'b0;
                    if (cnt_q == num_q) begin
                        state_d = ST_RD_ISSUE;
                        cnt_d   = '0;
                    end
                end else if (!cmd_valid_q && (cnt_q != num_q)) begin
                    address_d   = base_q + cnt_q;
                    writedata_d = wr_word;
                    wr_adv      = 1'b1;
                    cnt_d       = cnt_q + ADDR_WIDTH'(1);
                    cmd_valid_d = 1'b1;
                end
            end
            ST_RD_ISSUE: begin
                if (cmd_accept) begin
                    cmd_valid_d = 1'b0;
                    if (cnt_q == num_q) state_d = ST_RD_DRAIN;
                end else if (!cmd_valid_q && (cnt_q != num_q) &&
                             (outst_q < OUT_W'(MAX_OUTSTANDING))) begin
                    address_d   = base_q + cnt_q;
                    cnt_d       = cnt_q + ADDR_WIDTH'(1);
                    cmd_valid_d = 1'b1;
                end
            end
            ST_RD_DRAIN: begin
                if ((outst_q == '0) && (vld_q == '0)) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0) && !tmo_q;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Memory timeout abandons everything in flight
        if ((ddr_write_timeout || ddr_read_timeout) &&
            ((state_q == ST_WR_ISSUE) || rd_phase)) begin
            state_d     = ST_FINISH;
            tmo_d       = 1'b1;
            done_d      = 1'b1;
            pass_d      = 1'b0;
            cmd_valid_d = 1'b0;
            outst_d     = '0;
            vld_d       = '0;
            pop_d       = 1'b0;
        end
    end

    always_ff @(posedge pClk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            tmo_q       <= 1'b0;
            err_q       <= '0;
            ferr_q      <= '0;
            base_q      <= '0;
            num_q       <= '0;
            cnt_q       <= '0;
            cmp_addr_q  <= '0;
            address_q   <= '0;
            writedata_q <= '0;
            cmd_valid_q <= 1'b0;
            outst_q     <= '0;
            vld_q       <= '0;
            pop_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            ferr_q      <= ferr_d;
            base_q      <= base_d;
            num_q       <= num_d;
            cnt_q       <= cnt_d;
            cmp_addr_q  <= cmp_addr_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            cmd_valid_q <= cmd_valid_d;
            outst_q     <= outst_d;
            vld_q       <= vld_d;
            pop_q       <= pop_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout_err    = tmo_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;
    assign write          = wr_fire;
    assign read           = rd_fire;
    assign writedata      = writedata_q;
    assign address        = address_q;
    assign byteenable     = '1;
    assign burstcount     = BURSTCOUNT_WIDTH'(1);
    assign readdata_sel   = 3'd0;
    assign read_ddr_data  = pop_q;

endmodule

// File: tb/tb_mem_test_gen.sv
// Scoreboard bench for mem_test_gen with a latency-accurate memory model.
module tb_mem_test_gen;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 26;
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 7;
    localparam int unsigned RD_LAT = 4;

    logic          pClk, SoftReset_n, start;
    logic [AW-1:0] base_addr, num_words;
    logic [DW-1:0] seed;
    logic          busy, done, pass, timeout_err;
    logic [31:0]   err_count;
    logic [AW-1:0] first_err_addr, address;
    logic          write, read, read_ddr_data;
    logic [DW-1:0] writedata, readdata;
    logic [BW-1:0] byteenable;
    logic [CW-1:0] burstcount;
    logic [2:0]    readdata_sel;
    logic          ddr_data_ready, cmd_fifo_full, ddr_write_timeout, ddr_read_timeout;

    mem_test_gen dut (
        .pClk(pClk), .SoftReset_n(SoftReset_n), .start(start),
        .base_addr(base_addr), .num_words(num_words), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .timeout_err(timeout_err),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .write(write), .read(read), .writedata(writedata), .address(address),
        .byteenable(byteenable), .burstcount(burstcount), .readdata_sel(readdata_sel),
        .read_ddr_data(read_ddr_data), .ddr_data_ready(ddr_data_ready),
        .readdata(readdata), .cmd_fifo_full(cmd_fifo_full),
        .ddr_write_timeout(ddr_write_timeout), .ddr_read_timeout(ddr_read_timeout)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    typedef struct packed {
        logic          pass;
        logic [31:0]   err;
        logic [AW-1:0] addr;
        logic          tmo;
    } res_t;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } lat_t;

    int checks = 0;
    int errors = 0;

    res_t          exp_res[$];
    logic [AW-1:0] exp_wa[$];
    logic [DW-1:0] exp_wd[$];
    logic [AW-1:0] exp_ra[$];
    int            wr_base_idx = 0, rd_base_idx = 0;

    int            wr_ptr = 0, rd_ptr = 0, wr_cnt = 0, rd_cnt = 0, max_out = 0;
    int            res_ptr = 0, done_cnt = 0, mcyc = 0, start_cyc = 0, done_cyc = 0;
    logic          withhold = 1'b0, corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = 26'h105;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [DW-1:0] sd, input int i);
`ifdef MEM_TEST_LFSR_EN
        logic [DW-1:0] w;
        w = (sd == '0) ? DW'(1) : sd;
        for (int k = 0; k < i; k++)
            w = w[0] ? ((w >> 1) ^ 64'hD800_0000_0000_0000) : (w >> 1);
        return w;
`else
        return sd + DW'(i);
`endif
    endfunction

    // Memory model: records writes, queues reads, returns data RD_LAT cycles after a pop
    initial begin : model
        logic [DW-1:0] mem [logic [AW-1:0]];
        logic [AW-1:0] rdq[$];
        lat_t          latq[$];
        logic          prev_pulse;
        int            cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        prev_pulse = 1'b0;
        cyc = 0;
        readdata = '0;
        ddr_data_ready = 1'b0;
        forever begin
            @(negedge pClk);
            cyc++;
            if (!SoftReset_n) begin
                rdq.delete();
                latq.delete();
                prev_pulse = 1'b0;
            end else begin
                if (start && !busy) begin
                    rdq.delete();
                    latq.delete();
                    wr_ptr = wr_base_idx;
                    rd_ptr = rd_base_idx;
                    wr_cnt = 0;
                    rd_cnt = 0;
                    max_out = 0;
                end
                if (write) begin
                    wr_cnt++;
                    chk("write_while_full", cmd_fifo_full, 0);
                    chk("write_and_read", read, 0);
                    chk("byteenable", byteenable, 8'hFF);
                    chk("burstcount", burstcount, 1);
                    if (wr_ptr < exp_wa.size()) begin
                        chk("write_addr", address, exp_wa[wr_ptr]);
                        chk("write_data", writedata, exp_wd[wr_ptr]);
                    end else begin
                        chk("write_extra", wr_ptr, exp_wa.size());
                    end
                    wr_ptr++;
                    mem[address] = writedata;
                end
                if (read) begin
                    rd_cnt++;
                    chk("read_while_full", cmd_fifo_full, 0);
                    chk("readdata_sel", readdata_sel, 0);
                    if (rd_ptr < exp_ra.size())
                        chk("read_addr", address, exp_ra[rd_ptr]);
                    else
                        chk("read_extra", rd_ptr, exp_ra.size());
                    rd_ptr++;
                    rdq.push_back(address);
                    if (rdq.size() > max_out) max_out = rdq.size();
                end
                if (write || read) chk("cmd_gap", prev_pulse, 0);
                prev_pulse = write || read;
                if (read_ddr_data) begin
                    chk("pop_has_data", rdq.size() != 0, 1);
                    if (rdq.size() != 0) begin
                        a = rdq.pop_front();
                        d = mem.exists(a) ? mem[a] : '0;
                        if (corrupt_en && (a == corrupt_addr)) d = d ^ DW'(1);
                        latq.push_back('{due: cyc + RD_LAT, d: d});
                    end
                end
                if ((latq.size() != 0) && (latq[0].due == cyc)) begin
                    readdata = latq[0].d;
                    void'(latq.pop_front());
                end
            end
            ddr_data_ready = (rdq.size() != 0) && !withhold;
        end
    end

    // Result monitor: compares each done pulse against the next queued expectation
    initial begin : monitor
        forever begin
            @(negedge pClk);
            mcyc++;
            if (SoftReset_n && start && !busy) start_cyc = mcyc;
            if (SoftReset_n && done) begin
                done_cnt++;
                done_cyc = mcyc;
                if (res_ptr < exp_res.size()) begin
                    chk("res_pass", pass, exp_res[res_ptr].pass);
                    chk("res_err_count", err_count, exp_res[res_ptr].err);
                    chk("res_first_err_addr", first_err_addr, exp_res[res_ptr].addr);
                    chk("res_timeout_err", timeout_err, exp_res[res_ptr].tmo);
                    res_ptr++;
                end else begin
                    chk("unexpected_done", done, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic launch(input logic [AW-1:0] base, input int num, input logic [DW-1:0] sd,
                          input logic has_res, input res_t r);
        wr_base_idx = exp_wa.size();
        rd_base_idx = exp_ra.size();
        for (int i = 0; i < num; i++) begin
            exp_wa.push_back(base + AW'(i));
            exp_wd.push_back(pat(sd, i));
            exp_ra.push_back(base + AW'(i));
        end
        if (has_res) exp_res.push_back(r);
        @(posedge pClk); #1;
        base_addr = base;
        num_words = AW'(num);
        seed      = sd;
        start     = 1'b1;
        @(posedge pClk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && done_cnt < exp_res.size(); k++) @(negedge pClk);
        #1;
        chk("done_seen", done_cnt, exp_res.size());
    endtask

    task automatic check_stream(input string tag, input int n);
        chk({tag, "_writes"}, wr_cnt, n);
        chk({tag, "_reads"}, rd_cnt, n);
        chk({tag, "_wr_consumed"}, wr_ptr, exp_wa.size());
        chk({tag, "_rd_consumed"}, rd_ptr, exp_ra.size());
    endtask

    initial begin : stim
        int w0, r0, d0;
        SoftReset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_words = '0;
        seed = '0;
        cmd_fifo_full = 1'b0;
        ddr_write_timeout = 1'b0;
        ddr_read_timeout = 1'b0;

        repeat (3) @(negedge pClk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_write", write, 0);
        chk("rst_read", read, 0);
        chk("rst_pop", read_ddr_data, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err_addr", first_err_addr, 0);
        chk("rst_writedata", writedata, 0);
        chk("rst_address", address, 0);
        @(posedge pClk); #2;
        SoftReset_n = 1'b1;

        // Ideal memory, incrementing pattern
        launch(26'h100, 16, 64'h5, 1'b1, '{pass: 1'b1, err: 32'd0, addr: '0, tmo: 1'b0});
        wait_done(1000);
        check_stream("ideal", 16);
        repeat (2) @(negedge pClk);
        chk("idle_busy", busy, 0);
        chk("pass_held", pass, 1);

        // Single corrupted word
        corrupt_en = 1'b1;
        launch(26'h100, 16, 64'h5, 1'b1, '{pass: 1'b0, err: 32'd1, addr: 26'h105, tmo: 1'b0});
        wait_done(1000);
        corrupt_en = 1'b0;

        // Command queue full for 20 cycles mid-write
        launch(26'h200, 16, 64'h9, 1'b1, '{pass: 1'b1, err: 32'd0, addr: '0, tmo: 1'b0});
        for (int k = 0; k < 500 && wr_cnt < 4; k++) @(negedge pClk);
        @(posedge pClk); #1;
        cmd_fifo_full = 1'b1;
        w0 = wr_cnt;
        repeat (20) @(posedge pClk);
        chk("full_no_write", wr_cnt, w0);
        #1;
        cmd_fifo_full = 1'b0;
        wait_done(1000);
        check_stream("full", 16);

        // Withheld data stalls reads at 8 outstanding; addresses wrap
        withhold = 1'b1;
        launch(26'h3FF_FFF8, 16, 64'h77, 1'b1, '{pass: 1'b1, err: 32'd0, addr: '0, tmo: 1'b0});
        for (int k = 0; k < 500 && rd_cnt < 8; k++) @(negedge pClk);
        repeat (30) @(negedge pClk);
        chk("stall_reads", rd_cnt, 8);
        chk("stall_outstanding", max_out, 8);
        withhold = 1'b0;
        wait_done(1000);
        chk("max_outstanding", max_out, 8);
        check_stream("stall", 16);

        // Read timeout while draining
        withhold = 1'b1;
        launch(26'h40, 4, 64'h1234, 1'b1, '{pass: 1'b0, err: 32'd0, addr: '0, tmo: 1'b1});
        for (int k = 0; k < 500 && rd_cnt < 4; k++) @(negedge pClk);
        repeat (4) @(posedge pClk);
        #1 ddr_read_timeout = 1'b1;
        @(posedge pClk);
        #1 ddr_read_timeout = 1'b0;
        wait_done(100);
        withhold = 1'b0;
        repeat (5) @(negedge pClk);
        chk("timeout_sticky", timeout_err, 1);
        r0 = rd_cnt;
        chk("timeout_reads", r0, 4);

        // Zero-length test
        launch(26'h10, 0, 64'h3, 1'b1, '{pass: 1'b1, err: 32'd0, addr: '0, tmo: 1'b0});
        wait_done(20);
        chk("zero_len_latency", done_cyc - start_cyc, 1);

        // Reset mid-write aborts with no done pulse
        launch(26'h500, 16, 64'h1, 1'b0, '{pass: 1'b0, err: 32'd0, addr: '0, tmo: 1'b0});
        for (int k = 0; k < 500 && wr_cnt < 3; k++) @(negedge pClk);
        #2 SoftReset_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_write", write, 0);
        chk("abort_read", read, 0);
        chk("abort_address", address, 0);
        chk("abort_writedata", writedata, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        repeat (3) @(posedge pClk);
        #2 SoftReset_n = 1'b1;
        d0 = done_cnt;
        repeat (40) @(negedge pClk);
        chk("abort_no_done", done_cnt, d0);

        // Recovery after reset
        launch(26'h100, 3, 64'hABC, 1'b1, '{pass: 1'b1, err: 32'd0, addr: '0, tmo: 1'b0});
        wait_done(500);
        check_stream("recover", 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
